// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding, opcodes,
// ALU-op and ALU-control codes. Honours the optional MULTICYCLE_CTRL_BNE_EN macro.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    BNEEX   = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JEX     = 4'd12
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  function automatic logic is_byte_op(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_SB);
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  // Must list exactly the opcodes that DECODE dispatches to an execute state.
  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_LB, OP_SB, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
`ifdef MULTICYCLE_CTRL_BNE_EN
      OP_BNE:  return 1'b1;
`else
      OP_BNE:  return 1'b0;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's aluop and the R-type funct field onto the
// ALU operation code.
module aludec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [3:0] alucontrol
);

  // NOTE: every path assigns alucontrol because of this default, so no latch is inferred.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath (fetch/decode/execute/mem/wb).
// Define MULTICYCLE_CTRL_BNE_EN to add bne support through the BNEEX state.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] alucontrol,
  output logic       byte_enable,
  output logic       illegal_op
);

  statetype   state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch, take_branch;
  logic       irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;
`ifdef MULTICYCLE_CTRL_BNE_EN
  logic       branchn;
`endif

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW, OP_LB, OP_SB: state_d = MEMADR;
          OP_RTYPE:                   state_d = RTYPEEX;
          OP_BEQ:                     state_d = BEQEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:                     state_d = BNEEX;
`endif
          OP_ADDI:                    state_d = ADDIEX;
          OP_J:                       state_d = JEX;
          default:                    state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = is_store_op(op) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;
    pcwrite      = 1'b0;
    branch       = 1'b0;
`ifdef MULTICYCLE_CTRL_BNE_EN
    branchn      = 1'b0;
`endif
    illegal_raw  = 1'b0;
    byte_enable  = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
      end
      DECODE: begin
        alusrcb     = 2'b11;
        illegal_raw = ~op_legal(op);
      end
      MEMADR: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        byte_enable = is_byte_op(op);
      end
      MEMRD: begin
        iord        = 1'b1;
        byte_enable = is_byte_op(op);
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        byte_enable  = is_byte_op(op);
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        byte_enable  = is_byte_op(op);
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_BNE_EN
      BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branchn = 1'b1;
      end
`endif
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite_raw = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MULTICYCLE_CTRL_BNE_EN
  assign take_branch = (branch & zero) | (branchn & ~zero);
`else
  assign take_branch = branch & zero;
`endif

  // State sits in FETCH during reset; mask its write strobes until reset releases.
  assign pcen       = (pcwrite | take_branch) & ~reset;
  assign irwrite    = irwrite_raw  & ~reset;
  assign memwrite   = memwrite_raw & ~reset;
  assign regwrite   = regwrite_raw & ~reset;
  assign illegal_op = illegal_raw  & ~reset;

  aludec u_aludec (
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle expectations
// are queued as stimulus is planned, then popped and compared each cycle.
module tb_multicycle_controller;

  localparam logic [5:0] TB_RTYPE = 6'b000000;
  localparam logic [5:0] TB_LW    = 6'b100011;
  localparam logic [5:0] TB_SW    = 6'b101011;
  localparam logic [5:0] TB_LB    = 6'b100000;
  localparam logic [5:0] TB_SB    = 6'b101000;
  localparam logic [5:0] TB_BEQ   = 6'b000100;
  localparam logic [5:0] TB_BNE   = 6'b000101;
  localparam logic [5:0] TB_ADDI  = 6'b001000;
  localparam logic [5:0] TB_J     = 6'b000010;
  localparam logic [5:0] TB_BAD   = 6'b111111;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef enum int {L_F, L_D, L_MA, L_MR, L_MWB, L_MW, L_REX, L_RWB,
                    L_BEQ, L_BNE, L_AEX, L_AWB, L_JEX} lbl_t;

  typedef struct {
    string       tag;
    logic [17:0] exp;
    logic        zin;
  } sb_entry_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, byte_enable, illegal_op;
  logic [3:0] alucontrol;
  logic [17:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  sb_entry_t sb_q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .iord        (iord),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .pcsrc       (pcsrc),
    .pcen        (pcen),
    .alucontrol  (alucontrol),
    .byte_enable (byte_enable),
    .illegal_op  (illegal_op)
  );

  assign obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, pcen, alucontrol, byte_enable, illegal_op};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [5:0] o);
    case (o)
      TB_RTYPE, TB_LW, TB_SW, TB_LB, TB_SB, TB_BEQ, TB_ADDI, TB_J: return 1'b1;
      TB_BNE:  return BNE_EN;
      default: return 1'b0;
    endcase
  endfunction

  // Expected output vector for one cycle, packed in the same order as obs.
  function automatic logic [17:0] exp_outs(input lbl_t l, input logic [5:0] o,
                                           input logic [5:0] f, input logic z, input logic rst);
    logic e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_asa, e_pcen, e_be, e_ill;
    logic [1:0] e_asb, e_pcs;
    logic [3:0] e_alu;
    logic bop;
    {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_asa, e_pcen, e_be, e_ill} = '0;
    e_asb = 2'b00;
    e_pcs = 2'b00;
    e_alu = 4'b0010;
    bop   = (o == TB_LB) || (o == TB_SB);
    case (l)
      L_F:   begin e_asb = 2'b01; e_irw = ~rst; e_pcen = ~rst; end
      L_D:   begin e_asb = 2'b11; e_ill = ~rst & ~ref_legal(o); end
      L_MA:  begin e_asa = 1'b1; e_asb = 2'b10; e_be = bop; end
      L_MR:  begin e_iord = 1'b1; e_be = bop; end
      L_MWB: begin e_m2r = 1'b1; e_rw = 1'b1; e_be = bop; end
      L_MW:  begin e_iord = 1'b1; e_mw = 1'b1; e_be = bop; end
      L_REX: begin e_asa = 1'b1; e_alu = ref_alu(f); end
      L_RWB: begin e_rd = 1'b1; e_rw = 1'b1; end
      L_BEQ: begin e_asa = 1'b1; e_pcs = 2'b01; e_alu = 4'b0110; e_pcen = z; end
      L_BNE: begin e_asa = 1'b1; e_pcs = 2'b01; e_alu = 4'b0110; e_pcen = ~z; end
      L_AEX: begin e_asa = 1'b1; e_asb = 2'b10; end
      L_AWB: e_rw = 1'b1;
      L_JEX: begin e_pcs = 2'b10; e_pcen = 1'b1; end
      default: ;
    endcase
    return {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_asa, e_asb, e_pcs,
            e_pcen, e_alu, e_be, e_ill};
  endfunction

  // Called just after a falling edge with the DUT in FETCH. max_cycles > 0 stops
  // early, leaving the DUT in the last checked state.
  task automatic run_instr(input string name, input logic [5:0] op_i, input logic [5:0] funct_i,
                           input logic zero_br, input logic zero_other, input int max_cycles);
    lbl_t seq[$];
    sb_entry_t e;
    int n;
    seq.push_back(L_F);
    seq.push_back(L_D);
    case (op_i)
      TB_LW, TB_LB: begin seq.push_back(L_MA); seq.push_back(L_MR); seq.push_back(L_MWB); end
      TB_SW, TB_SB: begin seq.push_back(L_MA); seq.push_back(L_MW); end
      TB_RTYPE:     begin seq.push_back(L_REX); seq.push_back(L_RWB); end
      TB_BEQ:       seq.push_back(L_BEQ);
      TB_BNE:       if (BNE_EN) seq.push_back(L_BNE);
      TB_ADDI:      begin seq.push_back(L_AEX); seq.push_back(L_AWB); end
      TB_J:         seq.push_back(L_JEX);
      default: ;
    endcase
    n = (max_cycles > 0 && max_cycles < seq.size()) ? max_cycles : seq.size();
    for (int i = 0; i < n; i++) begin
      e.zin = (seq[i] == L_BEQ || seq[i] == L_BNE) ? zero_br : zero_other;
      e.tag = $sformatf("%s c%0d", name, i + 1);
      e.exp = exp_outs(seq[i], op_i, funct_i, e.zin, 1'b0);
      sb_q.push_back(e);
    end
    op    = op_i;
    funct = funct_i;
    while (sb_q.size() > 0) begin
      e    = sb_q.pop_front();
      zero = e.zin;
      #1;
      check(e.tag, {14'd0, obs}, {14'd0, e.exp});
      if (sb_q.size() > 0 || max_cycles == 0) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    op    = TB_BAD;
    funct = 6'b000000;
    zero  = 1'b1;

    @(negedge clk); #1;
    check("reset hold 1", {14'd0, obs}, {14'd0, exp_outs(L_F, op, funct, zero, 1'b1)});
    @(negedge clk); #1;
    check("reset hold 2", {14'd0, obs}, {14'd0, exp_outs(L_F, op, funct, zero, 1'b1)});
    @(negedge clk);
    reset = 1'b0;

    run_instr("lw",       TB_LW,    6'b000000, 1'b0, 1'b1, 0);
    run_instr("add",      TB_RTYPE, 6'b100000, 1'b0, 1'b0, 0);
    run_instr("sub",      TB_RTYPE, 6'b100010, 1'b0, 1'b1, 0);
    run_instr("or",       TB_RTYPE, 6'b100101, 1'b0, 1'b0, 0);
    run_instr("slt",      TB_RTYPE, 6'b101010, 1'b0, 1'b0, 0);
    run_instr("beq tkn",  TB_BEQ,   6'b000000, 1'b1, 1'b0, 0);
    run_instr("beq nt",   TB_BEQ,   6'b000000, 1'b0, 1'b1, 0);
    run_instr("sb",       TB_SB,    6'b000000, 1'b0, 1'b1, 0);
    run_instr("sw",       TB_SW,    6'b000000, 1'b0, 1'b0, 0);
    run_instr("lb",       TB_LB,    6'b000000, 1'b0, 1'b0, 0);
    run_instr("addi",     TB_ADDI,  6'b000000, 1'b0, 1'b1, 0);
    run_instr("j",        TB_J,     6'b000000, 1'b0, 1'b1, 0);
    run_instr("illegal",  TB_BAD,   6'b000000, 1'b0, 1'b0, 0);
    run_instr("bne z0",   TB_BNE,   6'b000000, 1'b0, 1'b1, 0);
    run_instr("bne z1",   TB_BNE,   6'b000000, 1'b1, 1'b0, 0);

    // Abort a lw in MEMRD with an asynchronous reset between clock edges.
    run_instr("lw abort", TB_LW,    6'b000000, 1'b0, 1'b0, 4);
    #2;
    reset = 1'b1;
    #1;
    check("async reset", {14'd0, obs}, {14'd0, exp_outs(L_F, op, funct, zero, 1'b1)});
    @(posedge clk);
    @(negedge clk); #1;
    check("reset after edge", {14'd0, obs}, {14'd0, exp_outs(L_F, op, funct, zero, 1'b1)});
    @(negedge clk);
    reset = 1'b0;
    run_instr("post rst", TB_ADDI,  6'b000000, 1'b0, 1'b0, 0);
    run_instr("final",    TB_J,     6'b000000, 1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
